// File: rtl/peak_detector.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : peak_detector                                                |
// | Purpose : Per-frame maximum search over a magnitude stream; reports    |
// |           peak value and its valid-sample index once per frame.        |
// | Option  : PEAK_DETECTOR_THRESHOLD_EN adds threshold / peakDetected.    |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module peak_detector #(
    parameter int DATA_WIDTH   = 18,
    parameter int FRAME_LENGTH = 1024,
    parameter int INDEX_WIDTH  = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   dataInValid,
    input  logic [DATA_WIDTH:0]    dataIn,
`ifdef PEAK_DETECTOR_THRESHOLD_EN
    input  logic [DATA_WIDTH:0]    threshold,
    output logic                   peakDetected,
`endif
    output logic [DATA_WIDTH:0]    peakValue,
    output logic [INDEX_WIDTH-1:0] peakIndex,
    output logic                   peakValid,
    output logic                   busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    localparam logic [INDEX_WIDTH-1:0] c_LAST = INDEX_WIDTH'(FRAME_LENGTH - 1);
    localparam logic [INDEX_WIDTH-1:0] c_ONE  = INDEX_WIDTH'(1);

    state_t                 r_state;
    logic [DATA_WIDTH:0]    r_runMax;
    logic [INDEX_WIDTH-1:0] r_runIdx;
    logic [INDEX_WIDTH-1:0] r_count;
    logic [DATA_WIDTH:0]    r_peakValue;
    logic [INDEX_WIDTH-1:0] r_peakIndex;
    logic                   r_peakValid;
    logic                   r_busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_runMax    <= '0;
            r_runIdx    <= '0;
            r_count     <= '0;
            r_peakValue <= '0;
            r_peakIndex <= '0;
            r_peakValid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_peakValid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state  <= ST_SEARCH;
                        r_busy   <= 1'b1;
                        r_runMax <= '0;
                        r_runIdx <= '0;
                        r_count  <= '0;
                    end
                end
                ST_SEARCH: begin
                    if (dataInValid) begin
                        // Strict compare keeps the first occurrence on ties.
                        if (dataIn > r_runMax) begin
                            r_runMax <= dataIn;
                            r_runIdx <= r_count;
                        end
                        if (r_count == c_LAST) begin
                            r_state <= ST_REPORT;
                            r_count <= '0;
                        end else begin
                            r_count <= r_count + c_ONE;
                        end
                    end
                end
                ST_REPORT: begin
                    r_peakValue <= r_runMax;
                    r_peakIndex <= r_runIdx;
                    r_peakValid <= 1'b1;
                    r_runMax    <= '0;
                    r_runIdx    <= '0;
                    r_count     <= '0;
                    if (enable) begin
                        r_state <= ST_SEARCH;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PEAK_DETECTOR_THRESHOLD_EN
    logic                w_start;
    logic [DATA_WIDTH:0] r_threshold;
    logic                r_peakDetected;

    // Threshold is latched only on the edge a new frame search begins.
    assign w_start = enable && ((r_state == ST_IDLE) || (r_state == ST_REPORT));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_threshold    <= '0;
            r_peakDetected <= 1'b0;
        end else begin
            if (r_state == ST_REPORT) begin
                r_peakDetected <= (r_runMax >= r_threshold);
            end
            if (w_start) begin
                r_threshold <= threshold;
            end
        end
    end

    assign peakDetected = r_peakDetected;
`else
    // No threshold comparison in this build.
`endif

    assign peakValue = r_peakValue;
    assign peakIndex = r_peakIndex;
    assign peakValid = r_peakValid;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_peak_detector.sv
`default_nettype none
// Bench for peak_detector: reference model keeps each frame as a queue and
// searches it when complete; directed frames plus randomized traffic.
module tb_peak_detector;

    localparam int DW = 18;
    localparam int FL = 8;
    localparam int IW = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          dataInValid;
    logic [DW:0]   dataIn;
    logic [DW:0]   threshold;
    logic          peakDetected;
    logic [DW:0]   peakValue;
    logic [IW-1:0] peakIndex;
    logic          peakValid;
    logic          busy;

    peak_detector #(.DATA_WIDTH(DW), .FRAME_LENGTH(FL), .INDEX_WIDTH(IW)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .dataInValid (dataInValid),
        .dataIn      (dataIn),
`ifdef PEAK_DETECTOR_THRESHOLD_EN
        .threshold   (threshold),
        .peakDetected(peakDetected),
`endif
        .peakValue   (peakValue),
        .peakIndex   (peakIndex),
        .peakValid   (peakValid),
        .busy        (busy)
    );

`ifndef PEAK_DETECTOR_THRESHOLD_EN
    assign peakDetected = 1'b0;
`endif

    always #5 clock = ~clock;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: 0 = idle, 1 = collecting, 2 = one reporting cycle.
    int          mMode = 0;
    int          frame[$];
    logic [DW:0] mThr = '0;
    int          eVal = 0, eIdx = 0, eValid = 0, eDet = 0;
    bit          started = 0;
    int          pulses = 0;
    int          pVal[256];
    int          pIdx[256];
    int          pDet[256];

    always @(posedge clock) begin
        int best, bi;
        if (reset) begin
            mMode = 0; frame.delete();
            eVal = 0; eIdx = 0; eValid = 0; eDet = 0; mThr = '0;
            started = 1;
        end else begin
            eValid = 0;
            case (mMode)
                0: if (enable) begin mMode = 1; frame.delete(); mThr = threshold; end
                1: if (dataInValid) begin
                       frame.push_back(int'(dataIn));
                       if (frame.size() == FL) mMode = 2;
                   end
                default: begin
                    best = 0; bi = 0;
                    foreach (frame[i]) if (frame[i] > best) begin best = frame[i]; bi = i; end
                    eVal = best; eIdx = bi; eValid = 1;
                    eDet = (best >= int'(mThr)) ? 1 : 0;
                    if (enable) begin mMode = 1; frame.delete(); mThr = threshold; end
                    else mMode = 0;
                end
            endcase
        end
        #1;
        if (started) begin
            chk("peakValid", 32'(peakValid), 32'(eValid));
            chk("peakValue", 32'(peakValue), 32'(eVal));
            chk("peakIndex", 32'(peakIndex), 32'(eIdx));
            chk("busy",      32'(busy),      (mMode != 0) ? 32'd1 : 32'd0);
`ifdef PEAK_DETECTOR_THRESHOLD_EN
            chk("peakDetected", 32'(peakDetected), 32'(eDet));
`endif
            if (peakValid) begin
                if (pulses < 256) begin
                    pVal[pulses] = int'(peakValue);
                    pIdx[pulses] = int'(peakIndex);
                    pDet[pulses] = int'(peakDetected);
                end
                pulses++;
            end
        end
    end

    task automatic cyc(input logic en, input logic v, input int d);
        @(negedge clock);
        enable      = en;
        dataInValid = v;
        dataIn      = d[DW:0];
    endtask

    int basic[8] = '{15697, 19616, 115035, 158777, 148355, 72510, 126546, 154320};
    int ties[8]  = '{5, 9, 9, 2, 0, 1, 9, 3};
    int fA[8]    = '{10, 20, 30, 40, 50, 60, 70, 300};
    int fR[8]    = '{100, 200, 50, 999, 3, 2, 1, 0};

    task automatic run_basic(input int thrMid);
        int p0;
        p0 = pulses;
        cyc(1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, basic[i]);
            if (i == 2 && thrMid >= 0) threshold = thrMid[DW:0];
        end
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("basic pulses", 32'(pulses), 32'(p0 + 1));
        chk("basic value",  32'(pVal[p0]), 32'd158777);
        chk("basic index",  32'(pIdx[p0]), 32'd3);
        chk("basic busy after", 32'(busy), 32'd0);
    endtask

    initial begin
        int p0;
        reset = 1'b1; enable = 1'b0; dataInValid = 1'b0; dataIn = '0; threshold = '0;
        repeat (3) @(negedge clock);
        chk("reset peakValue", 32'(peakValue), 32'd0);
        chk("reset peakIndex", 32'(peakIndex), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Basic peak
        run_basic(-1);

        // Ties with gaps
        p0 = pulses;
        cyc(1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, ties[i]);
            repeat (i % 3 + 1) cyc(0, 0, 0);
            if (i == 6) chk("ties early pulse", 32'(pulses), 32'(p0));
        end
        cyc(0, 0, 0);
        chk("ties pulses", 32'(pulses), 32'(p0 + 1));
        chk("ties value",  32'(pVal[p0]), 32'd9);
        chk("ties index",  32'(pIdx[p0]), 32'd1);

        // Back-to-back frames
        p0 = pulses;
        cyc(1, 0, 0);
        for (int i = 0; i < 8; i++) cyc(1, 1, fA[i]);
        cyc(1, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("b2b pulses", 32'(pulses), 32'(p0 + 2));
        chk("b2b A value", 32'(pVal[p0]), 32'd300);
        chk("b2b A index", 32'(pIdx[p0]), 32'd7);
        chk("b2b B value", 32'(pVal[p0 + 1]), 32'd0);
        chk("b2b B index", 32'(pIdx[p0 + 1]), 32'd0);

        // Reset mid-frame
        p0 = pulses;
        cyc(1, 0, 0);
        cyc(0, 1, 1); cyc(0, 1, 1000); cyc(0, 1, 3); cyc(0, 1, 4);
        @(negedge clock); reset = 1'b1; dataInValid = 1'b0;
        @(negedge clock); reset = 1'b0;
        chk("rst peakValue", 32'(peakValue), 32'd0);
        chk("rst peakIndex", 32'(peakIndex), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        repeat (3) cyc(0, 0, 0);
        chk("rst no pulse", 32'(pulses), 32'(p0));
        cyc(1, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, fR[i]);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("post-rst value", 32'(pVal[p0]), 32'd999);
        chk("post-rst index", 32'(pIdx[p0]), 32'd3);

`ifdef PEAK_DETECTOR_THRESHOLD_EN
        threshold = 19'd150000;
        run_basic(-1);
        chk("thr 150000 det", 32'(pDet[pulses - 1]), 32'd1);
        threshold = 19'd160000;
        run_basic(-1);
        chk("thr 160000 det", 32'(pDet[pulses - 1]), 32'd0);
        threshold = 19'd160000;
        run_basic(0);
        chk("thr mid-frame det", 32'(pDet[pulses - 1]), 32'd0);
`endif

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            int r;
            @(negedge clock);
            reset       = ($urandom % 300) == 0;
            enable      = ($urandom % 5) != 0;
            dataInValid = ($urandom % 4) != 0;
            r           = ($urandom % 2) ? int'($urandom % 16) : int'($urandom % (1 << (DW + 1)));
            dataIn      = r[DW:0];
            r           = int'($urandom % (1 << (DW + 1)));
            threshold   = r[DW:0];
        end
        @(negedge clock);
        reset = 1'b0; enable = 1'b0; dataInValid = 1'b0;
        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
